// File: rtl/gf2m_pkg.sv
// gf2m_pkg: shared constants, state encoding and the x-multiply helper for the GF(2^m) multiplier
//   M    field degree (operand/result width)
//   D    digit width, bits of B consumed per cycle
//   N    digits per operand, ceil(M/D)
//   NDW  zero-extended B width, N*D
//   CW   digit counter width
//   POLY f(x) with the x^M term removed (sect163)
package gf2m_pkg;
   localparam int M = 163;
   localparam int D = 4;
   localparam int N = (M + D - 1) / D;
   localparam int NDW = N * D;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [M-1:0] POLY = 163'hC9;
   typedef enum logic {IDLE, RUN} state_t;
   // v*x mod f: shift left one place, fold the bit leaving position M-1 back in via POLY
   function automatic logic [M-1:0] mulx_mod(input logic [M-1:0] v);
      return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY : '0);
   endfunction
endpackage

// File: rtl/gf2m_digit_step.sv
// gf2m_digit_step: one digit-serial iteration, y = (acc*x^D + ar*digit) mod f
//   acc    in  M  running accumulator
//   ar     in  M  latched multiplicand
//   digit  in  D  current digit of the multiplier, MSB first
//   y      out M  next accumulator value
module gf2m_digit_step
   import gf2m_pkg::*;
(
   input  logic [M-1:0] acc,
   input  logic [M-1:0] ar,
   input  logic [D-1:0] digit,
   output logic [M-1:0] y
);
   logic [M-1:0] shifted;
   logic [M-1:0] partial;
   always_comb begin
      shifted = acc;
      partial = '0;
      for (int i = 0; i < D; i++) shifted = mulx_mod(shifted);
      // Horner over the digit bits keeps every intermediate reduced to M bits
      for (int i = D - 1; i >= 0; i--) partial = mulx_mod(partial) ^ (digit[i] ? ar : '0);
      y = shifted ^ partial;
   end
endmodule

// File: rtl/gf2m_digit_mul.sv
// gf2m_digit_mul: digit-serial GF(2^m) multiplier, C = A*B mod f(x), MSB-first, one digit per clock
//   CLK        in  1  clock
//   RST_N      in  1  synchronous active-low reset
//   IN_VALID   in  1  start pulse, A/B sampled on the same edge
//   A, B       in  M  multiplicand, multiplier
//   OUT_VALID  out 1  one-cycle pulse, C valid from this cycle on
//   C          out M  result register, held until the next OUT_VALID
//   BUSY       out 1  operation in progress
//   ERROR      out 1  one-cycle pulse after IN_VALID arrived while busy
module gf2m_digit_mul
   import gf2m_pkg::*;
(
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         IN_VALID,
   input  logic [M-1:0] A,
   input  logic [M-1:0] B,
   output logic         OUT_VALID,
   output logic [M-1:0] C,
   output logic         BUSY,
   output logic         ERROR
);
   state_t state, state_nxt;
   logic [CW-1:0] cnt;
   logic [M-1:0] ar, acc, acc_nxt;
   logic [NDW-1:0] br;
   logic [D-1:0] digit;
   assign digit = br[cnt*D +: D];
   assign BUSY = (state == RUN);
   gf2m_digit_step u_step (
      .acc   (acc),
      .ar    (ar),
      .digit (digit),
      .y     (acc_nxt)
   );
   always_comb begin
      state_nxt = state;
      if (state == IDLE && IN_VALID) state_nxt = RUN;
      else if (state == RUN && cnt == '0) state_nxt = IDLE;
   end
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state     <= IDLE;
         cnt       <= '0;
         ar        <= '0;
         br        <= '0;
         acc       <= '0;
         C         <= '0;
         OUT_VALID <= 1'b0;
         ERROR     <= 1'b0;
      end else begin
         state     <= state_nxt;
         OUT_VALID <= 1'b0;
         ERROR     <= (state == RUN) && IN_VALID;
         if (state == IDLE && IN_VALID) begin
            ar  <= A;
            br  <= NDW'(B);
            acc <= '0;
            cnt <= CW'(N - 1);
         end else if (state == RUN) begin
            acc <= acc_nxt;
            if (cnt == '0) begin
               C         <= acc_nxt;
               OUT_VALID <= 1'b1;
            end else begin
               cnt <= cnt - 1'b1;
            end
         end
      end
   end
endmodule
